// File: rtl/bitslam_voice_shaper_pkg.sv
// Shared constants and types for the bitslam voice shaper and its envelope.
package bitslam_pkg;

  localparam int unsigned BUS_W = 6;

  localparam logic [BUS_W-1:0] ADDR_MAX_PHASE = 6'h00;
  localparam logic [BUS_W-1:0] ADDR_CTRL      = 6'h01;
  localparam logic [BUS_W-1:0] ADDR_PW        = 6'h02;
  localparam logic [BUS_W-1:0] ADDR_ATTACK    = 6'h03;
  localparam logic [BUS_W-1:0] ADDR_RELEASE   = 6'h04;

  localparam logic [5:0] LEVEL_MAX = 6'd63;

  typedef enum logic [1:0] {
    WAVE_SAW   = 2'd0,
    WAVE_PULSE = 2'd1,
    WAVE_TRI   = 2'd2,
    WAVE_NOISE = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/bitslam_voice_shaper_envelope.sv
// Attack/sustain/release envelope: prescaled 6-bit level driven by a gate.
module bitslam_envelope
  import bitslam_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic [5:0] attack_rate,
  input  logic [5:0] release_rate,
  output logic [5:0] level,
  output logic       active
);

  env_state_t state;
  logic [5:0] prescale;
  logic       attack_step;
  logic       release_step;

  assign attack_step  = (prescale == attack_rate);
  assign release_step = (prescale == release_rate);
  assign active       = (state != ENV_IDLE);

  // Gate edges are tested before the step so they win on a coincident cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ENV_IDLE;
      level    <= '0;
      prescale <= '0;
    end else begin
      case (state)
        ENV_IDLE: begin
          level    <= '0;
          prescale <= '0;
          if (gate) state <= ENV_ATTACK;
        end
        ENV_ATTACK: begin
          if (!gate) begin
            state    <= ENV_RELEASE;
            prescale <= '0;
          end else if (attack_step) begin
            prescale <= '0;
            if (level >= LEVEL_MAX - 6'd1) begin
              level <= LEVEL_MAX;
              state <= ENV_SUSTAIN;
            end else begin
              level <= level + 6'd1;
            end
          end else begin
            prescale <= prescale + 6'd1;
          end
        end
        ENV_SUSTAIN: begin
          level    <= LEVEL_MAX;
          prescale <= '0;
          if (!gate) state <= ENV_RELEASE;
        end
        ENV_RELEASE: begin
          if (gate) begin
            state    <= ENV_ATTACK;
            prescale <= '0;
          end else if (release_step) begin
            prescale <= '0;
            if (level <= 6'd1) begin
              level <= '0;
              state <= ENV_IDLE;
            end else begin
              level <= level - 6'd1;
            end
          end else begin
            prescale <= prescale + 6'd1;
          end
        end
        default: begin
          state    <= ENV_IDLE;
          level    <= '0;
          prescale <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bitslam_voice_shaper.sv
// Phase-to-sample voice shaper: waveform select, envelope scaling, bus registers.
// Noise source is built only when BITSLAM_SHAPER_NOISE_EN is defined.
module bitslam_voice_shaper
  import bitslam_pkg::*;
#(
  parameter logic [5:0] PW_RESET  = 6'h20,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             addr_data_sel,
  input  logic [BUS_W-1:0] addr_data,
  input  logic [7:0]       phase,
  output logic [7:0]       sample_out,
  output logic             env_active
);

  logic [BUS_W-1:0] addr;
  wave_t            waveform;
  logic             gate;
  logic [5:0]       pw;
  logic [5:0]       attack_rate;
  logic [5:0]       release_rate;

  logic [5:0]       level;
  logic             active;
  logic [7:0]       noise;
  logic [7:0]       wave;
  logic [7:0]       scaled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr         <= '0;
      waveform     <= WAVE_SAW;
      gate         <= 1'b0;
      pw           <= PW_RESET;
      attack_rate  <= '0;
      release_rate <= '0;
    end else if (!addr_data_sel) begin
      addr <= addr_data;
    end else begin
      case (addr)
        ADDR_CTRL: begin
          waveform <= wave_t'(addr_data[1:0]);
          gate     <= addr_data[2];
        end
        ADDR_PW:      pw           <= addr_data;
        ADDR_ATTACK:  attack_rate  <= addr_data;
        ADDR_RELEASE: release_rate <= addr_data;
        default: ;
      endcase
    end
  end

  bitslam_envelope u_envelope (
    .clk          (clk),
    .rst_n        (rst_n),
    .gate         (gate),
    .attack_rate  (attack_rate),
    .release_rate (release_rate),
    .level        (level),
    .active       (active)
  );

`ifdef BITSLAM_SHAPER_NOISE_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (phase == 8'h00) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign noise = lfsr;
`else
  assign noise = '0;
`endif

  always_comb begin
    wave = '0;
    case (waveform)
      WAVE_SAW:   wave = phase;
      WAVE_PULSE: wave = (phase < {pw, 2'b00}) ? 8'hFF : 8'h00;
      WAVE_TRI:   wave = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      WAVE_NOISE: wave = noise;
      default:    wave = '0;
    endcase
  end

  // Full 14-bit product, keep bits [13:6]; 255 * 63 >> 6 tops out at 251.
  assign scaled = 8'((14'(wave) * 14'(level)) >> 6);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= '0;
      env_active <= 1'b0;
    end else begin
      sample_out <= scaled;
      env_active <= active;
    end
  end

endmodule

// File: tb/tb_bitslam_voice_shaper.sv
// Directed self-checking bench for bitslam_voice_shaper.
module tb_bitslam_voice_shaper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       addr_data_sel = 1'b0;
  logic [5:0] addr_data = '0;
  logic [7:0] phase = 8'h80;
  logic [7:0] sample_out;
  logic       env_active;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  bitslam_voice_shaper #(
    .PW_RESET  (6'h20),
    .LFSR_SEED (8'h01)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .addr_data_sel (addr_data_sel),
    .addr_data     (addr_data),
    .phase         (phase),
    .sample_out    (sample_out),
    .env_active    (env_active)
  );

  task automatic tick(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [5:0] d);
    addr_data_sel = 1'b0;
    addr_data     = a;
    tick();
    addr_data_sel = 1'b1;
    addr_data     = d;
    tick();
    addr_data_sel = 1'b0;
    addr_data     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    phase = 8'h80;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sample_out !== 8'h00) $display("FAIL reset_sample: got %h expected %h", sample_out, 8'h00);
    else passed++;
    total++;
    if (env_active !== 1'b0) $display("FAIL reset_env_active: got %b expected %b", env_active, 1'b0);
    else passed++;
    tick(2);
    rst_n = 1'b1;
    tick();
    total++;
    if (sample_out !== 8'h00) $display("FAIL reset_first_cycle: got %h expected %h", sample_out, 8'h00);
    else passed++;
  endtask

  task automatic test_bus_decode();
    logic [5:0] bad_a [5];
    logic [5:0] bad_d [5];
    bad_a = '{6'h00, 6'h05, 6'h09, 6'h06, 6'h22};
    bad_d = '{6'h05, 6'h05, 6'h04, 6'h00, 6'h00};
    do_reset();
    phase = 8'h80;
    for (int unsigned i = 0; i < 5; i++) wr(bad_a[i], bad_d[i]);
    tick(3);
    total++;
    if (env_active !== 1'b0) $display("FAIL decode_no_gate: got %b expected %b", env_active, 1'b0);
    else passed++;
    total++;
    if (sample_out !== 8'h00) $display("FAIL decode_no_sample: got %h expected %h", sample_out, 8'h00);
    else passed++;
    // pulse with untouched pw=0x20: threshold 0x80
    wr(6'h01, 6'h05);
    tick(66);
    phase = 8'h7F;
    tick();
    total++;
    if (sample_out !== 8'hFB) $display("FAIL decode_pw_below: got %h expected %h", sample_out, 8'hFB);
    else passed++;
    phase = 8'h80;
    tick();
    total++;
    if (sample_out !== 8'h00) $display("FAIL decode_pw_at: got %h expected %h", sample_out, 8'h00);
    else passed++;
  endtask

  task automatic test_attack_sustain();
    do_reset();
    phase = 8'h80;
    wr(6'h03, 6'h00);
    wr(6'h01, 6'h04);
    tick();
    total++;
    if (env_active !== 1'b0) $display("FAIL attack_env_lag: got %b expected %b", env_active, 1'b0);
    else passed++;
    tick();
    total++;
    if (env_active !== 1'b1) $display("FAIL attack_env_on: got %b expected %b", env_active, 1'b1);
    else passed++;
    tick(31);
    total++;
    if (sample_out !== 8'h3E) $display("FAIL attack_mid: got %h expected %h", sample_out, 8'h3E);
    else passed++;
    tick(31);
    total++;
    if (sample_out !== 8'h7C) $display("FAIL attack_level62: got %h expected %h", sample_out, 8'h7C);
    else passed++;
    tick();
    total++;
    if (sample_out !== 8'h7E) $display("FAIL attack_level63: got %h expected %h", sample_out, 8'h7E);
    else passed++;
    tick(5);
    total++;
    if (sample_out !== 8'h7E) $display("FAIL sustain_hold: got %h expected %h", sample_out, 8'h7E);
    else passed++;
  endtask

  task automatic test_reset_mid_note();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sample_out !== 8'h00) $display("FAIL midreset_sample_async: got %h expected %h", sample_out, 8'h00);
    else passed++;
    total++;
    if (env_active !== 1'b0) $display("FAIL midreset_env_async: got %b expected %b", env_active, 1'b0);
    else passed++;
    tick(2);
    rst_n = 1'b1;
    tick();
    total++;
    if (sample_out !== 8'h00) $display("FAIL midreset_first_cycle: got %h expected %h", sample_out, 8'h00);
    else passed++;
    tick(3);
    total++;
    if (env_active !== 1'b0) $display("FAIL midreset_idle: got %b expected %b", env_active, 1'b0);
    else passed++;
    wr(6'h01, 6'h05);
    tick(66);
    phase = 8'h7F;
    tick();
    total++;
    if (sample_out !== 8'hFB) $display("FAIL midreset_pw_default_lo: got %h expected %h", sample_out, 8'hFB);
    else passed++;
    phase = 8'h80;
    tick();
    total++;
    if (sample_out !== 8'h00) $display("FAIL midreset_pw_default_hi: got %h expected %h", sample_out, 8'h00);
    else passed++;
  endtask

  task automatic test_release();
    do_reset();
    phase = 8'h80;
    wr(6'h03, 6'h00);
    wr(6'h04, 6'h03);
    wr(6'h01, 6'h04);
    tick(70);
    wr(6'h01, 6'h00);
    for (int unsigned m = 1; m <= 254; m++) begin
      tick();
      if (m == 5 || m == 6 || m == 9 || m == 10 || m == 253 || m == 254) begin
        logic [7:0] es;
        logic       ea;
        case (m)
          5:       begin es = 8'h7E; ea = 1'b1; end
          6:       begin es = 8'h7C; ea = 1'b1; end
          9:       begin es = 8'h7C; ea = 1'b1; end
          10:      begin es = 8'h7A; ea = 1'b1; end
          253:     begin es = 8'h02; ea = 1'b1; end
          default: begin es = 8'h00; ea = 1'b0; end
        endcase
        total++;
        if (sample_out !== es) $display("FAIL release_sample m=%0d: got %h expected %h", m, sample_out, es);
        else passed++;
        total++;
        if (env_active !== ea) $display("FAIL release_env m=%0d: got %b expected %b", m, env_active, ea);
        else passed++;
      end
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] exp_s [6];
    exp_s = '{8'h50, 8'h50, 8'h4E, 8'h3C, 8'h3C, 8'h3E};
    do_reset();
    phase = 8'h80;
    wr(6'h03, 6'h00);
    wr(6'h04, 6'h00);
    wr(6'h01, 6'h04);
    tick(39);
    wr(6'h01, 6'h00);
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sample_out !== exp_s[i]) $display("FAIL retrig_release i=%0d: got %h expected %h", i, sample_out, exp_s[i]);
      else passed++;
    end
    tick(6);
    wr(6'h01, 6'h04);
    for (int unsigned i = 3; i < 6; i++) begin
      tick();
      total++;
      if (sample_out !== exp_s[i]) $display("FAIL retrig_attack i=%0d: got %h expected %h", i, sample_out, exp_s[i]);
      else passed++;
    end
    total++;
    if (env_active !== 1'b1) $display("FAIL retrig_env: got %b expected %b", env_active, 1'b1);
    else passed++;
  endtask

  task automatic test_pulse_boundary();
    logic [5:0] pw_v [9];
    logic [7:0] ph_v [9];
    logic [7:0] ex_v [9];
    pw_v = '{6'h10, 6'h10, 6'h10, 6'h10, 6'h00, 6'h00, 6'h00, 6'h3F, 6'h3F};
    ph_v = '{8'h3F, 8'h40, 8'h00, 8'hFF, 8'h00, 8'h3F, 8'hFF, 8'hFB, 8'hFC};
    ex_v = '{8'hFB, 8'h00, 8'hFB, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFB, 8'h00};
    do_reset();
    phase = 8'h80;
    wr(6'h02, 6'h10);
    wr(6'h01, 6'h05);
    tick(66);
    for (int unsigned i = 0; i < 9; i++) begin
      if (i == 4 || i == 7) wr(6'h02, pw_v[i]);
      phase = ph_v[i];
      tick();
      total++;
      if (sample_out !== ex_v[i])
        $display("FAIL pulse pw=%h phase=%h: got %h expected %h", pw_v[i], ph_v[i], sample_out, ex_v[i]);
      else passed++;
    end
  endtask

  task automatic test_tri_saw();
    logic [1:0] wf_v [8];
    logic [7:0] ph_v [8];
    logic [7:0] ex_v [8];
    wf_v = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    ph_v = '{8'h40, 8'hC0, 8'hFF, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h40};
    ex_v = '{8'h7E, 8'h7D, 8'h00, 8'hFA, 8'h00, 8'hFB, 8'h00, 8'h3F};
    wr(6'h01, 6'h06);
    for (int unsigned i = 0; i < 8; i++) begin
      if (i == 5) wr(6'h01, 6'h04);
      phase = ph_v[i];
      tick();
      total++;
      if (sample_out !== ex_v[i])
        $display("FAIL wave%0d phase=%h: got %h expected %h", wf_v[i], ph_v[i], sample_out, ex_v[i]);
      else passed++;
    end
  endtask

  task automatic test_noise();
    logic [7:0] ph_v [10];
    logic [7:0] ex_v [10];
    ph_v = '{8'h80, 8'h00, 8'h55, 8'h55, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h20};
`ifdef BITSLAM_SHAPER_NOISE_EN
    // lfsr 01 -> 02 -> 04 -> 08 -> 11, scaled by 63/64
    ex_v = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h03, 8'h07, 8'h07, 8'h07, 8'h10};
`else
    ex_v = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    do_reset();
    phase = 8'h80;
    wr(6'h01, 6'h07);
    tick(66);
    for (int unsigned i = 0; i < 10; i++) begin
      phase = ph_v[i];
      tick();
      total++;
      if (sample_out !== ex_v[i])
        $display("FAIL noise i=%0d phase=%h: got %h expected %h", i, ph_v[i], sample_out, ex_v[i]);
      else passed++;
    end
    total++;
    if (env_active !== 1'b1) $display("FAIL noise_env: got %b expected %b", env_active, 1'b1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_bus_decode();
    test_attack_sustain();
    test_reset_mid_note();
    test_release();
    test_retrigger();
    test_pulse_boundary();
    test_tri_saw();
    test_noise();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
